// File: rtl/tripack_if.sv
// rtl/tripack_if.sv - input-beat and packed-word stream bundle for tripack
interface tripack_if #(
  parameter int VLEN = 256,
  parameter int BSW  = 5,
  parameter int WW   = 8 - BSW + 1
);
  localparam int BS = 1 << BSW;

  logic            in_valid;
  logic            in_ready;
  logic [BSW:0]    inum;
  logic [WW-1:0]   ilen [BS];
  logic [BSW-1:0]  ipos [BS];
  logic [VLEN-1:0] ivec;
  logic            in_last;

  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] out_data;
  logic [BSW:0]    out_nbytes;
  logic            out_last;

  modport slave (
    input  in_valid, inum, ilen, ipos, ivec, in_last, out_ready,
    output in_ready, out_valid, out_data, out_nbytes, out_last
  );

  modport master (
    output in_valid, inum, ilen, ipos, ivec, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_nbytes, out_last
  );
endinterface

// File: rtl/tripack.sv
// rtl/tripack.sv - gathers variable-length elements per beat into a dense byte stream of VLEN-bit words
module tripack #(
  parameter int VLEN = 256,
  parameter int BSW  = 5,
  parameter int WW   = 8 - BSW + 1
) (
  input  logic      clk,
  input  logic      rstn,
  tripack_if.slave  s,
  output logic      err
);
  localparam int BS   = 1 << BSW;
  localparam int PW   = BSW + 2;
  localparam int LMAX = (1 << WW) - 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [BSW-1:0]  cnt_q, cnt_d;
  logic [7:0]      res_q [BS];
  logic [7:0]      res_d [BS];
  logic            out_valid_q, out_valid_d;
  logic [VLEN-1:0] out_data_q, out_data_d;
  logic [BSW:0]    out_nbytes_q, out_nbytes_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;

  logic [PW-1:0]   prev [BS+1];
  logic [PW-1:0]   tot;
  logic [PW-1:0]   n_sum;
  logic            bad;
  logic [7:0]      sbuf [2*BS];
  logic            out_free;
  logic            accept;

  assign out_free   = !out_valid_q || s.out_ready;
  assign s.in_ready = rstn && (state_q == RUN) && out_free;
  assign accept     = s.in_valid && s.in_ready;

  // Prefix sums saturate at 2*BS so a long element list cannot wrap back below BS.
  always_comb begin
    logic [PW-1:0] psum;
    psum    = '0;
    bad     = 1'b0;
    prev[0] = '0;
    for (int j = 0; j < BS; j++) begin
      if ((BSW+1)'(j) < s.inum) begin
        psum      = prev[j] + PW'(s.ilen[j]);
        prev[j+1] = (psum > PW'(2*BS)) ? PW'(2*BS) : psum;
        if (PW'(s.ipos[j]) + PW'(s.ilen[j]) > PW'(BS)) bad = 1'b1;
      end else begin
        prev[j+1] = prev[j];
      end
    end
    if (prev[BS] > PW'(BS)) bad = 1'b1;
    tot   = (prev[BS] > PW'(BS)) ? PW'(BS) : prev[BS];
    n_sum = PW'(cnt_q) + tot;
  end

  // Stream buffer: residue at the bottom, this beat's elements appended behind it.
  always_comb begin
    logic [PW-1:0] off;
    logic [PW-1:0] src;
    logic [PW-1:0] dst;
    off = '0;
    src = '0;
    dst = '0;
    for (int i = 0; i < BS; i++) sbuf[i] = (BSW'(i) < cnt_q) ? res_q[i] : 8'h00;
    for (int i = BS; i < 2*BS; i++) sbuf[i] = 8'h00;
    for (int j = 0; j < BS; j++) begin
      for (int b = 0; b <= LMAX; b++) begin
        off = prev[j] + PW'(b);
        src = PW'(s.ipos[j]) + PW'(b);
        dst = PW'(cnt_q) + off;
        if (((BSW+1)'(j) < s.inum) && (PW'(b) < PW'(s.ilen[j])) && (off < PW'(BS))) begin
          sbuf[dst[BSW:0]] = (src < PW'(BS)) ? s.ivec[8*src[BSW-1:0] +: 8] : 8'h00;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_nbytes_d = out_nbytes_q;
    out_last_d   = out_last_q;
    err_d        = err_q;
    if (out_valid_q && s.out_ready) out_valid_d = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (bad) err_d = 1'b1;
          if (n_sum >= PW'(BS)) begin
            out_valid_d  = 1'b1;
            out_nbytes_d = (BSW+1)'(BS);
            out_last_d   = s.in_last && (n_sum == PW'(BS));
            for (int i = 0; i < BS; i++) begin
              out_data_d[8*i +: 8] = sbuf[i];
              res_d[i]             = sbuf[BS+i];
            end
            cnt_d = BSW'(n_sum - PW'(BS));
            if (s.in_last && (n_sum > PW'(BS))) state_d = FLUSH;
          end else if (s.in_last) begin
            out_valid_d  = 1'b1;
            out_nbytes_d = n_sum[BSW:0];
            out_last_d   = 1'b1;
            for (int i = 0; i < BS; i++) begin
              out_data_d[8*i +: 8] = sbuf[i];
              res_d[i]             = 8'h00;
            end
            cnt_d = '0;
          end else begin
            for (int i = 0; i < BS; i++) res_d[i] = sbuf[i];
            cnt_d = n_sum[BSW-1:0];
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_valid_d  = 1'b1;
          out_nbytes_d = {1'b0, cnt_q};
          out_last_d   = 1'b1;
          for (int i = 0; i < BS; i++) begin
            out_data_d[8*i +: 8] = res_q[i];
            res_d[i]             = 8'h00;
          end
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      res_q        <= '{default: 8'h00};
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_nbytes_q <= out_nbytes_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
    end
  end

  assign s.out_valid  = out_valid_q;
  assign s.out_data   = out_data_q;
  assign s.out_nbytes = out_nbytes_q;
  assign s.out_last   = out_last_q;
  assign err          = err_q;
endmodule

// File: tb/tb_tripack.sv
// tb/tb_tripack.sv - directed self-checking bench for tripack
module tb_tripack;
  logic clk = 1'b0;
  logic rstn;
  logic err;

  tripack_if bus ();

  tripack u_dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus),
    .err  (err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         el_len [5];
  int         el_pos [5];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one beat (ivec byte b = base+b) and appends the bytes it should contribute.
  task automatic load_beat(input int base, input int n, input bit last);
    int tot;
    tot = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.inum     = 6'(n);
    for (int b = 0; b < 32; b++) bus.ivec[8*b +: 8] = 8'(base + b);
    for (int j = 0; j < 32; j++) begin
      bus.ilen[j] = (j < 5) ? 4'(el_len[j]) : 4'd0;
      bus.ipos[j] = (j < 5) ? 5'(el_pos[j]) : 5'd0;
    end
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < el_len[j]; b++) begin
        if (tot < 32) exp_q.push_back((el_pos[j] + b < 32) ? 8'(base + el_pos[j] + b) : 8'h00);
        tot++;
      end
    end
  endtask

  function automatic logic [255:0] peek_word(input int n);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = (i < exp_q.size()) ? exp_q[i] : 8'hxx;
    return w;
  endfunction

  task automatic expect_word(input string tag, input int n, input bit last);
    logic [255:0] w;
    w = peek_word(n);
    for (int i = 0; i < n; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, ".valid"}, bus.out_valid, 1);
    check({tag, ".data"}, bus.out_data, w);
    check({tag, ".nbytes"}, bus.out_nbytes, n);
    check({tag, ".last"}, bus.out_last, last);
  endtask

  initial begin
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.inum      = '0;
    bus.ivec      = '0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      bus.ilen[j] = '0;
      bus.ipos[j] = '0;
    end
    el_len = '{0, 0, 0, 0, 0};
    el_pos = '{0, 0, 0, 0, 0};
    tick();
    tick();
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.out_data", bus.out_data, 0);
    check("rst.out_nbytes", bus.out_nbytes, 0);
    check("rst.out_last", bus.out_last, 0);
    check("rst.err", err, 0);
    rstn = 1'b1;
    #1;
    check("rst.in_ready_up", bus.in_ready, 1);

    // Eight T=8 beats give two full words.
    for (int k = 0; k < 8; k++) begin
      el_len = '{1, 2, 3, 2, 0};
      el_pos = '{0, 4, 8, 12, 0};
      load_beat(k * 32, 4, 1'b0);
      check("t1.in_ready", bus.in_ready, 1);
      tick();
      if (k % 4 == 3) expect_word("t1.word", 32, 1'b0);
      else check("t1.idle", bus.out_valid, 0);
      check("t1.cnt", u_dut.cnt_q, ((k + 1) % 4) * 8);
    end
    bus.in_valid = 1'b0;
    tick();
    check("t1.drain", bus.out_valid, 0);

    // T=20 then T=20 with in_last: full word, then an 8-byte flush word.
    el_len = '{12, 8, 0, 0, 0};
    el_pos = '{0, 16, 0, 0, 0};
    load_beat(0, 2, 1'b0);
    tick();
    check("t2.no_word", bus.out_valid, 0);
    check("t2.cnt20", u_dut.cnt_q, 20);
    load_beat(64, 2, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    expect_word("t2.full", 32, 1'b0);
    check("t2.flush_ready", bus.in_ready, 0);
    tick();
    expect_word("t2.flush", 8, 1'b1);
    check("t2.cnt0", u_dut.cnt_q, 0);
    tick();
    check("t2.drain", bus.out_valid, 0);

    // Empty terminator.
    el_len = '{0, 0, 0, 0, 0};
    load_beat(0, 0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    expect_word("t3.empty", 0, 1'b1);
    tick();

    // Backpressure: word held 5 cycles, then released with a beat in the same cycle.
    bus.out_ready = 1'b0;
    el_len = '{1, 2, 3, 2, 0};
    el_pos = '{0, 4, 8, 12, 0};
    for (int k = 0; k < 4; k++) begin
      load_beat(k * 32 + 3, 4, 1'b0);
      tick();
    end
    load_beat(200, 4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("t4.hold_ready", bus.in_ready, 0);
      check("t4.hold_valid", bus.out_valid, 1);
      check("t4.hold_data", bus.out_data, peek_word(32));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4.rel_ready", bus.in_ready, 1);
    expect_word("t4.rel", 32, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t4.consumed", bus.out_valid, 0);
    check("t4.cnt8", u_dut.cnt_q, 8);
    el_len = '{0, 0, 0, 0, 0};
    load_beat(0, 0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    expect_word("t4.tail", 8, 1'b1);
    tick();

    // Oversized beat: T=40 clamps to one 32-byte word and sets sticky err.
    check("t5.err_before", err, 0);
    el_len = '{8, 8, 8, 8, 8};
    el_pos = '{0, 8, 16, 24, 0};
    load_beat(16, 5, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t5.err", err, 1);
    expect_word("t5.clamp", 32, 1'b0);
    check("t5.cnt0", u_dut.cnt_q, 0);
    tick();
    check("t5.err_sticky", err, 1);

    // Reset with residue 12 discards everything; next stream starts at offset 0.
    el_len = '{8, 4, 0, 0, 0};
    el_pos = '{0, 8, 0, 0, 0};
    load_beat(32, 2, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t6.cnt12", u_dut.cnt_q, 12);
    rstn = 1'b0;
    #1;
    check("t6.rst_ready", bus.in_ready, 0);
    tick();
    check("t6.out_valid", bus.out_valid, 0);
    check("t6.out_data", bus.out_data, 0);
    check("t6.out_nbytes", bus.out_nbytes, 0);
    check("t6.out_last", bus.out_last, 0);
    check("t6.err", err, 0);
    check("t6.cnt", u_dut.cnt_q, 0);
    exp_q.delete();
    rstn = 1'b1;
    el_len = '{4, 0, 0, 0, 0};
    el_pos = '{0, 0, 0, 0, 0};
    load_beat(144, 1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    expect_word("t6.restart", 4, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
